regfile_writeback_ctrl: RTL and testbench

Write-side controller for the 32×32 register file. It owns the single write port (A3/WD3/WE3) and arbitrates between the single-cycle ALU pipeline and a long-latency unit (divider or memory) that returns results out of order through a valid/ready handshake. A per-register busy scoreboard produces the decode-stage stall that keeps readers from seeing stale data. It sits between the execute/long-latency units and the register file.

---
 rtl/regfile_writeback_ctrl.sv | 112 +++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Write-port controller for the 32x32 register file: ALU results take priority,
// long-latency results queue in a small FIFO, and a busy scoreboard drives decode stall.
module regfile_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_we,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_wd,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic                    ll_valid,
  input  logic [4:0]              ll_rd,
  input  logic [XLEN-1:0]         ll_wd,
  output logic                    ll_ready,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    stall,
  output logic [31:0]             busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [4:0]              A3,
  output logic [XLEN-1:0]         WD3,
  output logic                    WE3
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]      fifo_rd [DEPTH];
  logic [XLEN-1:0] fifo_wd [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  logic            src_ll;
  logic [31:0]     busy_q;
  logic [31:0]     busy_next;
  logic            alu_sel;
  logic            push;
  logic            pop;

  assign ll_ready   = rst && (count < (AW+1)'(DEPTH));
  assign alu_sel    = alu_we && (alu_rd != 5'd0);
  // A handshake with rd=0 completes but stores nothing.
  assign push       = ll_valid && ll_ready && (ll_rd != 5'd0);
  // Pop looks only at the registered count, so a same-edge push is never bypassed.
  assign pop        = rst && !alu_sel && (count != '0);
  assign fifo_count = count;
  assign busy       = busy_q;

  assign stall = ((rs1 != 5'd0) && busy_q[rs1]) ||
                 ((rs2 != 5'd0) && busy_q[rs2]) ||
                 (iss_valid && (iss_rd != 5'd0) && busy_q[iss_rd]);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy_q;
    if (WE3 && src_ll) busy_next[A3] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail] <= ll_rd;
      fifo_wd[tail] <= ll_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      A3     <= '0;
      WD3    <= '0;
      WE3    <= 1'b0;
      src_ll <= 1'b0;
    end else if (alu_sel) begin
      A3     <= alu_rd;
      WD3    <= alu_wd;
      WE3    <= 1'b1;
      src_ll <= 1'b0;
    end else if (pop) begin
      A3     <= fifo_rd[head];
      WD3    <= fifo_wd[head];
      WE3    <= 1'b1;
      src_ll <= 1'b1;
    end else begin
      WE3    <= 1'b0;
      src_ll <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl: a queue-based reference model predicts
// register-file writes, busy bits, FIFO occupancy, stall and ll_ready.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_we, iss_valid, ll_valid;
  logic [4:0]      alu_rd, iss_rd, ll_rd, rs1, rs2;
  logic [XLEN-1:0] alu_wd, ll_wd;
  logic            ll_ready, stall, WE3;
  logic [31:0]     busy;
  logic [2:0]      fifo_count;
  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_wd(ll_wd), .ll_ready(ll_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy), .fifo_count(fifo_count),
    .A3(A3), .WD3(WD3), .WE3(WE3)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // Reference model state
  wr_t        pend_q[$];   // results accepted by the FIFO, not yet written
  wr_t        exp_q[$];    // writes the register file must see, in order
  logic [31:0] busy_m = '0;
  logic [4:0]  clr_pending = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the model's prediction for the edge that follows.
  task automatic step(input logic r,
                      input logic awe, input logic [4:0] ard, input logic [XLEN-1:0] awd,
                      input logic iv, input logic [4:0] ird,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] lwd,
                      input logic [4:0] s1, input logic [4:0] s2,
                      output logic accepted);
    bit  ready_m;
    bit  stall_m;
    wr_t e;
    @(negedge clk);
    rst = r; alu_we = awe; alu_rd = ard; alu_wd = awd;
    iss_valid = iv; iss_rd = ird; ll_valid = lv; ll_rd = lrd; ll_wd = lwd;
    rs1 = s1; rs2 = s2;
    #1;
    ready_m = r && (pend_q.size() < DEPTH);
    stall_m = (s1 != 0 && busy_m[s1]) || (s2 != 0 && busy_m[s2]) || (iv && ird != 0 && busy_m[ird]);
    if (mon_en) begin
      check("stall", stall, stall_m);
      check("ll_ready", ll_ready, ready_m);
    end
    accepted = lv && ready_m;
    if (!r) begin
      pend_q.delete();
      busy_m      = '0;
      clr_pending = '0;
    end else begin
      if (clr_pending != 0) busy_m[clr_pending] = 1'b0;
      if (iv && ird != 0) busy_m[ird] = 1'b1;
      clr_pending = '0;
      if (awe && ard != 0) begin
        exp_q.push_back('{rd: ard, wd: awd});
      end else if (pend_q.size() > 0) begin
        e = pend_q.pop_front();
        exp_q.push_back(e);
        clr_pending = e.rd;
      end
      if (accepted && lrd != 0) pend_q.push_back('{rd: lrd, wd: lwd});
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  // Monitor: compares every register-file write and the registered status outputs.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (WE3) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual A3=%0d WD3=%0h expected no write at %0t", A3, WD3, $time);
          end else begin
            e = exp_q.pop_front();
            check("A3", A3, e.rd);
            check("WD3", WD3, e.wd);
          end
        end
        check("busy", busy, busy_m);
        check("fifo_count", fifo_count, pend_q.size());
      end
    end
  end

  initial begin
    logic acc;
    int   guard;
    // Reset held two cycles with ll_valid asserted
    step(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h11, 0, 0, acc);
    mon_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h11, 0, 0, acc);
    check("reset_ll_ready", ll_ready, 1'b0);
    check("reset_WE3", WE3, 1'b0);
    check("reset_A3", A3, 5'd0);
    check("reset_WD3", WD3, 32'd0);
    idle(1);
    check("release_ll_ready", ll_ready, 1'b1);

    // ALU write to x5, then an ALU write to x0 that must not reach the port
    step(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 1, 5'd0, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, acc);
    idle(2);

    // Long-latency op to x7 with a dependent reader on rs1
    step(1, 0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, acc);
    step(1, 0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 0, acc);   // WAW guard
    step(1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1234, 5'd7, 0, acc);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, acc);

    // ALU contention: three writes to x3 while x9 waits in the FIFO
    step(1, 1, 5'd3, 32'h30, 1, 5'd9, 1, 5'd9, 32'h99, 0, 0, acc);
    step(1, 1, 5'd3, 32'h31, 0, 0, 0, 0, 0, 5'd9, 0, acc);
    step(1, 1, 5'd3, 32'h32, 0, 0, 0, 0, 0, 5'd9, 0, acc);
    idle(4);

    // Backpressure: fill the FIFO under continuous ALU writes, fifth result waits
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 5'd2, 32'h200 + i, 1, 5'(10 + i), 1, 5'(10 + i), 32'hA00 + i, 0, 0, acc);
    step(1, 1, 5'd2, 32'h2FF, 1, 5'd14, 1, 5'd14, 32'hA04, 0, 0, acc);
    check("full_refuses", acc, 1'b0);
    check("full_count", fifo_count, 3'd4);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 20) begin
      step(1, 0, 0, 0, 0, 0, 1, 5'd14, 32'hA04, 0, 0, acc);
      guard++;
    end
    check("fifth_accepted", acc, 1'b1);
    idle(8);

    // Mid-operation reset with FIFO entries and a busy bit pending
    step(1, 1, 5'd1, 32'h1, 1, 5'd7, 1, 5'd7, 32'h7, 0, 0, acc);
    step(1, 1, 5'd1, 32'h2, 1, 5'd8, 1, 5'd8, 32'h8, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd8, acc);
    idle(4);
    check("post_reset_busy", busy, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    end
    idle(10);
    check("drained_expected", exp_q.size(), 0);
    check("drained_fifo", fifo_count, 3'd0);
    check("drained_busy", busy, busy_m);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
